// File: rtl/seed_loader.sv
// Serial seed loader for the Game of Life core: shifts in a full board, optionally
// checks a trailing even-parity bit, then bursts one row per cycle into the state file.
// Latency: last bit (or parity bit) -> 2**REGBITS write cycles -> load_done -> idle;
// no backpressure: sin_valid gaps stall the shifter, and busy freezes generation stepping.
//
// Ports: ph1 clock; reset_n sync active-low reset; load_req starts a load from IDLE;
//   sin_valid/sin_data serial cell stream (row 0 first, column 0 / MSB first);
//   busy high outside IDLE; we/waddr/wdata row write port (addr/data zero when we=0);
//   load_done one-cycle pulse after the last row write; load_err sticky parity failure.
// Build option: define SEED_PARITY_EN to expect one trailing even-parity bit after the board.
module seed_loader #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic               ph1,
  input  logic               reset_n,
  input  logic               load_req,
  input  logic               sin_valid,
  input  logic               sin_data,
  output logic               busy,
  output logic               we,
  output logic [REGBITS-1:0] waddr,
  output logic [WIDTH-1:0]   wdata,
  output logic               load_done,
  output logic               load_err
);

  localparam int ROWS  = 2**REGBITS;
  localparam int NBITS = WIDTH * ROWS;
  localparam int CNTW  = $clog2(NBITS);
  localparam logic [CNTW-1:0]    LAST_BIT = CNTW'(NBITS - 1);
  localparam logic [REGBITS-1:0] LAST_ROW = REGBITS'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               shift_en;
  logic [REGBITS-1:0] waddr_d;
  logic [WIDTH-1:0]   wdata_d;
  logic               we_d;

  // The board is one long shift chain threaded through the rows: the first bit
  // received ends up in rows_q[0][WIDTH-1] once all NBITS have arrived.
  logic [WIDTH-1:0]   rows_q  [ROWS];
  logic [WIDTH-1:0]   rows_nx [ROWS];

`ifdef SEED_PARITY_EN
  logic par_q, par_d;
  logic err_q, err_d;
`endif

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    waddr_d  = '0;
`ifdef SEED_PARITY_EN
    par_d    = par_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = SHIFT;
          cnt_d   = '0;
`ifdef SEED_PARITY_EN
          par_d   = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          shift_en = 1'b1;
`ifdef SEED_PARITY_EN
          par_d    = par_q ^ sin_data;
`endif
          if (cnt_q == LAST_BIT) begin
`ifdef SEED_PARITY_EN
            state_d = PARITY;
`else
            state_d = WRITE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SEED_PARITY_EN
      PARITY: begin
        if (sin_valid) begin
          if (par_q ^ sin_data) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end
`endif
      WRITE: begin
        // waddr doubles as the row counter; entry into WRITE always starts at row 0.
        if (waddr == LAST_ROW) state_d = DONE;
        else                   waddr_d = waddr + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shifted view of the buffer; the write data is taken from it so that the
  // first row is correct on the same edge that accepts the final board bit.
  always_comb begin
    rows_nx = rows_q;
    if (shift_en) begin
      for (int r = 0; r < ROWS - 1; r++)
        rows_nx[r] = {rows_q[r][WIDTH-2:0], rows_q[r+1][WIDTH-1]};
      rows_nx[ROWS-1] = {rows_q[ROWS-1][WIDTH-2:0], sin_data};
    end
    we_d    = (state_d == WRITE);
    wdata_d = we_d ? rows_nx[waddr_d] : '0;
  end

  always_ff @(posedge ph1) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy      <= 1'b0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      load_done <= 1'b0;
`ifdef SEED_PARITY_EN
      par_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy      <= (state_d != IDLE);
      we        <= we_d;
      waddr     <= waddr_d;
      wdata     <= wdata_d;
      load_done <= (state_d == DONE);
`ifdef SEED_PARITY_EN
      par_q     <= par_d;
      err_q     <= err_d;
`endif
    end
  end

  // Data-only storage; never written out unless a full board has been shifted in.
  always_ff @(posedge ph1) begin
    rows_q <= rows_nx;
  end

`ifdef SEED_PARITY_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule
